// File: rtl/crossing_frame_scheduler.sv
// Frame scheduler: forwards one camera frame into the pattern-recognition pipeline, waits for its
// verdict, and debounces it into crossing_stable. Define CROSSING_SCHED_TIMEOUT_EN for the drain timeout.
module crossing_frame_scheduler #(
  parameter int IMG_WIDTH      = 320,
  parameter int IMG_HEIGHT     = 240,
  parameter int W              = 8,
  parameter int CONFIRM_FRAMES = 3,
  parameter int RELEASE_FRAMES = 3,
  parameter int DRAIN_TIMEOUT  = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         cam_valid,
  output logic         cam_ready,
  input  logic [W-1:0] cam_data,
  output logic         pr_x_valid,
  input  logic         pr_x_ready,
  output logic [W-1:0] pr_x_data,
  input  logic         pr_detection_valid,
  input  logic         pr_crossing_detected,
  output logic         crossing_stable,
  output logic         frame_done,
  output logic [15:0]  frame_count,
  output logic         busy,
  output logic         timeout_err,
  output logic [1:0]   state_dbg
);

  localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
  localparam int PIX_W  = $clog2(NPIX) + 1;
  localparam int HIT_W  = $clog2(CONFIRM_FRAMES) + 1;
  localparam int MISS_W = $clog2(RELEASE_FRAMES) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2, DECIDE = 2'd3} state_t;

  state_t              state, state_next;
  logic [PIX_W-1:0]    pix_cnt;
  logic [HIT_W-1:0]    hit_cnt;
  logic [MISS_W-1:0]   miss_cnt;
  logic                verdict, got;
  logic                pix_accept, last_pix, drain_expire;

  // Handshake: a pixel moves on any cycle where valid and ready are both high in STREAM;
  // the camera sees the pipeline's ready directly, so no buffering sits in between.
  assign pr_x_data = cam_data;
  assign last_pix  = (pix_cnt == PIX_W'(NPIX - 1));
  assign busy      = (state != IDLE);
  assign state_dbg = state;

`ifdef CROSSING_SCHED_TIMEOUT_EN
  localparam int DRN_W = $clog2(DRAIN_TIMEOUT) + 1;
  logic [DRN_W-1:0] drain_cnt;
  logic             timeout_q;

  assign drain_expire = (state == DRAIN) && !got && !pr_detection_valid &&
                        (drain_cnt == DRN_W'(DRAIN_TIMEOUT - 1));
  assign timeout_err  = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      if (drain_expire) timeout_q <= 1'b1;
    end
  end
`else
  assign drain_expire = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  always_comb begin
    state_next = state;
    cam_ready  = 1'b0;
    pr_x_valid = 1'b0;
    frame_done = 1'b0;
    pix_accept = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: if (enable) state_next = STREAM;
        STREAM: begin
          pr_x_valid = cam_valid;
          cam_ready  = pr_x_ready;
          pix_accept = cam_valid && pr_x_ready;
          if (pix_accept && last_pix) state_next = DRAIN;
        end
        DRAIN: if (got || pr_detection_valid || drain_expire) state_next = DECIDE;
        DECIDE: begin
          frame_done = 1'b1;
          state_next = enable ? STREAM : IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pix_cnt         <= '0;
      verdict         <= 1'b0;
      got             <= 1'b0;
      hit_cnt         <= '0;
      miss_cnt        <= '0;
      crossing_stable <= 1'b0;
      frame_count     <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE || state == DECIDE) pix_cnt <= '0;
      else if (pix_accept)                  pix_cnt <= pix_cnt + 1'b1;

      // Verdicts only count while a frame is in flight; the latest pulse overwrites earlier ones.
      if ((state == STREAM || state == DRAIN) && pr_detection_valid) begin
        verdict <= pr_crossing_detected;
        got     <= 1'b1;
      end else if (drain_expire) begin
        verdict <= 1'b0;
      end

      if (state == DECIDE) begin
        got         <= 1'b0;
        frame_count <= frame_count + 16'd1;
        if (verdict) begin
          miss_cnt <= '0;
          if (hit_cnt < HIT_W'(CONFIRM_FRAMES)) hit_cnt <= hit_cnt + 1'b1;
          if (hit_cnt >= HIT_W'(CONFIRM_FRAMES - 1)) crossing_stable <= 1'b1;
        end else begin
          hit_cnt <= '0;
          if (miss_cnt < MISS_W'(RELEASE_FRAMES)) miss_cnt <= miss_cnt + 1'b1;
          if (miss_cnt >= MISS_W'(RELEASE_FRAMES - 1)) crossing_stable <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_crossing_frame_scheduler.sv
// Bench for crossing_frame_scheduler on a 4x2 frame with 2-frame hysteresis and a 16-cycle drain timeout.
module tb_crossing_frame_scheduler;
  localparam int W = 8;
  localparam logic [1:0] S_IDLE = 2'd0, S_STREAM = 2'd1, S_DRAIN = 2'd2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         cam_valid = 1'b0;
  logic         cam_ready;
  logic [W-1:0] cam_data = '0;
  logic         pr_x_valid;
  logic         pr_x_ready = 1'b1;
  logic [W-1:0] pr_x_data;
  logic         pr_detection_valid = 1'b0;
  logic         pr_crossing_detected = 1'b0;
  logic         crossing_stable, frame_done, busy, timeout_err;
  logic [15:0]  frame_count;
  logic [1:0]   state_dbg;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int m_hit = 0, m_miss = 0;
  logic m_stable = 1'b0;
  logic [15:0] m_count = '0;

  crossing_frame_scheduler #(
    .IMG_WIDTH(4), .IMG_HEIGHT(2), .W(W),
    .CONFIRM_FRAMES(2), .RELEASE_FRAMES(2), .DRAIN_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cam_valid(cam_valid), .cam_ready(cam_ready), .cam_data(cam_data),
    .pr_x_valid(pr_x_valid), .pr_x_ready(pr_x_ready), .pr_x_data(pr_x_data),
    .pr_detection_valid(pr_detection_valid), .pr_crossing_detected(pr_crossing_detected),
    .crossing_stable(crossing_stable), .frame_done(frame_done), .frame_count(frame_count),
    .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Output-side scoreboard: every pixel leaving toward the pipeline must match the next one driven.
  always @(negedge clk) begin
    if (!rst && pr_x_valid && pr_x_ready) begin
      xfer_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pix_extra: got %0h, required no transfer", pr_x_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (pr_x_data !== e) begin
          errors++;
          $display("FAIL pix_data: got %0h, required %0h", pr_x_data, e);
        end
      end
    end
  end

  task automatic model_update(input bit v);
    if (v) begin
      m_miss = 0;
      if (m_hit < 2) m_hit++;
      if (m_hit == 2) m_stable = 1'b1;
    end else begin
      m_hit = 0;
      if (m_miss < 2) m_miss++;
      if (m_miss == 2) m_stable = 1'b0;
    end
    m_count = m_count + 16'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; cam_valid = 1'b0; pr_detection_valid = 1'b0; pr_x_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_hit = 0; m_miss = 0; m_stable = 1'b0; m_count = '0;
  endtask

  task automatic start_stream();
    enable = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_pixels(input int n, input bit toggle_ready, input int drop_after);
    int sent = 0;
    int cyc = 0;
    bit accepted;
    logic [W-1:0] px;
    px = W'($urandom_range(0, 255));
    exp_q.push_back(px);
    cam_data = px; cam_valid = 1'b1;
    while (sent < n && cyc < 100) begin
      pr_x_ready = toggle_ready ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (toggle_ready) begin
        checks++;
        if (cam_ready !== pr_x_ready) begin
          errors++;
          $display("FAIL ready_mirror: cam_ready %b, required %b", cam_ready, pr_x_ready);
        end
      end
      accepted = cam_valid && cam_ready;
      @(posedge clk); #1;
      cyc++;
      if (accepted) begin
        sent++;
        if (sent == drop_after) enable = 1'b0;
        if (sent < n) begin
          px = W'($urandom_range(0, 255));
          exp_q.push_back(px);
          cam_data = px;
        end else cam_valid = 1'b0;
      end
    end
    cam_valid = 1'b0; pr_x_ready = 1'b1;
    checks++;
    if (sent != n) begin
      errors++;
      $display("FAIL send_timeout: sent %0d, required %0d", sent, n);
    end
  endtask

  // Deliver an optional verdict after `delay` cycles, wait for frame_done, then check bookkeeping.
  task automatic finish_frame(input int delay, input bit give, input bit v, output int waited);
    bit seen = 0;
    waited = 0;
    if (give) begin
      repeat (delay) @(posedge clk);
      #1;
      pr_detection_valid = 1'b1; pr_crossing_detected = v;
    end
    while (!seen && waited < 60) begin
      @(negedge clk);
      waited++;
      if (frame_done) seen = 1;
      else begin
        @(posedge clk); #1;
        pr_detection_valid = 1'b0;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_done_wait: no pulse in %0d cycles, required one", waited);
    end
    @(posedge clk); #1;
    pr_detection_valid = 1'b0;
    model_update(give ? v : 1'b0);
    checks++;
    if (frame_count !== m_count) begin
      errors++;
      $display("FAIL frame_count: got %0d, required %0d", frame_count, m_count);
    end
    checks++;
    if (crossing_stable !== m_stable) begin
      errors++;
      $display("FAIL crossing_stable: got %b, required %b (frame %0d)", crossing_stable, m_stable, m_count);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_width: got %b after pulse, required 0", frame_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int w;
    do_reset();
    start_stream();
    cam_data = 8'hA5; cam_valid = 1'b1; pr_x_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cam_ready !== 1'b0 || pr_x_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: cam_ready %b pr_x_valid %b, required 0 0", cam_ready, pr_x_valid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || frame_count !== 16'd0 || crossing_stable !== 1'b0 ||
        frame_done !== 1'b0 || timeout_err !== 1'b0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: busy %b count %0d stable %b done %b tmo %b state %0d, required all 0",
               busy, frame_count, crossing_stable, frame_done, timeout_err, state_dbg);
    end
    cam_valid = 1'b0;
    w = 0;
    do_reset();
  endtask

  task automatic test_basic();
    int w;
    do_reset();
    start_stream();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b, required 1", busy);
    end
    send_pixels(8, 1'b0, 8);
    checks++;
    if (state_dbg !== S_DRAIN) begin
      errors++;
      $display("FAIL basic_drain: state %0d, required %0d", state_dbg, S_DRAIN);
    end
    finish_frame(2, 1'b1, 1'b1, w);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_idle: busy %b pending %0d, required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic run_pattern(input logic [3:0] pat);
    int w;
    do_reset();
    start_stream();
    for (int i = 0; i < 4; i++) begin
      send_pixels(8, 1'b0, (i == 3) ? 8 : 0);
      finish_frame(1 + i, 1'b1, pat[3-i], w);
    end
  endtask

  task automatic test_hysteresis();
    run_pattern(4'b1100);
    checks++;
    if (crossing_stable !== 1'b0) begin
      errors++;
      $display("FAIL hyst_release: got %b after two misses, required 0", crossing_stable);
    end
    run_pattern(4'b1010);
  endtask

  task automatic test_backpressure();
    int w;
    int base;
    do_reset();
    start_stream();
    base = xfer_cnt;
    send_pixels(8, 1'b1, 8);
    pr_x_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (xfer_cnt - base != 8) begin
      errors++;
      $display("FAIL bp_count: got %0d transfers, required 8", xfer_cnt - base);
    end
    checks++;
    if (state_dbg !== S_DRAIN || cam_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: state %0d cam_ready %b, required %0d 0", state_dbg, cam_ready, S_DRAIN);
    end
    @(posedge clk); #1;
    finish_frame(1, 1'b1, 1'b0, w);
  endtask

  task automatic test_timeout();
    int w;
    do_reset();
    start_stream();
    send_pixels(8, 1'b0, 8);
`ifdef CROSSING_SCHED_TIMEOUT_EN
    finish_frame(0, 1'b0, 1'b0, w);
    checks++;
    if (w != 17) begin
      errors++;
      $display("FAIL tmo_latency: DECIDE after %0d DRAIN cycles, required 16", w - 1);
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_flag: got %b, required 1", timeout_err);
    end
    start_stream();
    send_pixels(8, 1'b0, 8);
    finish_frame(1, 1'b1, 1'b1, w);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky: got %b, required 1", timeout_err);
    end
`else
    w = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done) w++;
    end
    checks++;
    if (busy !== 1'b1 || w != 0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL no_tmo_wait: busy %b pulses %0d tmo %b, required 1 0 0", busy, w, timeout_err);
    end
    @(posedge clk); #1;
`endif
    do_reset();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clear: got %b after reset, required 0", timeout_err);
    end
  endtask

  task automatic test_enable_drop();
    int w;
    int base;
    do_reset();
    start_stream();
    base = xfer_cnt;
    send_pixels(8, 1'b0, 3);
    checks++;
    if (xfer_cnt - base != 8 || state_dbg !== S_DRAIN) begin
      errors++;
      $display("FAIL drop_complete: %0d transfers state %0d, required 8 %0d", xfer_cnt - base, state_dbg, S_DRAIN);
    end
    finish_frame(2, 1'b1, 1'b1, w);
    checks++;
    if (busy !== 1'b0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL drop_idle: busy %b state %0d, required 0 %0d", busy, state_dbg, S_IDLE);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    start_stream();
    send_pixels(8, 1'b0, 0);
    finish_frame(1, 1'b1, 1'b1, w);
    send_pixels(5, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; enable = 1'b0;
    m_hit = 0; m_miss = 0; m_stable = 1'b0; m_count = '0;
    checks++;
    if (state_dbg !== S_IDLE || busy !== 1'b0 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: state %0d busy %b count %0d, required %0d 0 0", state_dbg, busy, frame_count, S_IDLE);
    end
    start_stream();
    send_pixels(7, 1'b0, 0);
    checks++;
    if (state_dbg !== S_STREAM) begin
      errors++;
      $display("FAIL mid_restart: state %0d after 7 pixels, required %0d", state_dbg, S_STREAM);
    end
    send_pixels(1, 1'b0, 1);
    checks++;
    if (state_dbg !== S_DRAIN) begin
      errors++;
      $display("FAIL mid_full: state %0d after 8 pixels, required %0d", state_dbg, S_DRAIN);
    end
    finish_frame(1, 1'b1, 1'b0, w);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hysteresis();
    test_backpressure();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_pixels: %0d never forwarded, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
